// File: rtl/product_accumulator.sv
// Product accumulator: sums groups of unsigned multiplier products over valid/ready.
// Emits per-group sum, saturating beat count and sticky carry flag.
module product_accumulator #(
    parameter int N     = 8,
    parameter int ACC_W = 2*N+8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    localparam int PW = 2*N;

    typedef enum logic {
        ST_ACC,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             oovf_q, oovf_d;

    logic             accept;
    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] cnt_inc;

    assign accept  = in_valid && in_ready;
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W+1-PW){1'b0}}, in_product};
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACC:  if (accept && in_last) state_d = ST_DONE;
            ST_DONE: if (out_ready)         state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_ACC) && !clear;
        out_valid = (state_q == ST_DONE);
    end

    // Result registers only move when a group closes; they persist past the handshake.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        sum_d  = sum_q;
        ocnt_d = ocnt_q;
        oovf_d = oovf_q;
        if (state_q == ST_ACC) begin
            if (clear) begin
                acc_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
            end else if (accept) begin
                if (in_last) begin
                    sum_d  = sum_ext[ACC_W-1:0];
                    ocnt_d = cnt_inc;
                    oovf_d = ovf_q | sum_ext[ACC_W];
                    acc_d  = '0;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                end else begin
                    acc_d = sum_ext[ACC_W-1:0];
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | sum_ext[ACC_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            sum_q  <= '0;
            ocnt_q <= '0;
            oovf_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            sum_q  <= sum_d;
            ocnt_q <= ocnt_d;
            oovf_q <= oovf_d;
        end
    end

    assign out_sum      = sum_q;
    assign out_count    = ocnt_q;
    assign out_overflow = oovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and random checks for product_accumulator (N=8, ACC_W=16, CNT_W=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge or #1 after rising.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_product;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [7:0]  out_count;
    logic        out_overflow;

    int checks = 0;
    int errors = 0;

    product_accumulator #(.N(8), .ACC_W(16), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear(clear),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_product(in_product),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_count(out_count),
        .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    task automatic beat(input logic [15:0] p, input logic last);
        bit done;
        done = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: product %0d never accepted", p);
        end
    endtask

    task automatic get_result(input bit rnd, output logic [15:0] s,
                              output logic [7:0] c, output logic o);
        bit got;
        got = 0;
        s = '0;
        c = '0;
        o = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            out_ready = (rnd && i < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                s   = out_sum;
                c   = out_count;
                o   = out_overflow;
                got = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: out_valid never seen");
        end
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_product = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0b expected 0", out_valid);
        end
        checks++;
        if (out_sum !== 16'd0 || out_count !== 8'd0 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: got %0d/%0d/%0b expected 0/0/0",
                     out_sum, out_count, out_overflow);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %0b expected 1", in_ready);
        end
    endtask

    task automatic test_basic;
        beat(16'd6, 1'b0);
        beat(16'd20, 1'b0);
        beat(16'd72, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_valid: got %0b expected 1", out_valid);
        end
        checks++;
        if (out_sum !== 16'd98 || out_count !== 8'd3 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %0d/%0d/%0b expected 98/3/0",
                     out_sum, out_count, out_overflow);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_done: got %0b expected 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_cycle: got %0b expected 0", out_valid);
        end
        checks++;
        if (out_sum !== 16'd98) begin
            errors++;
            $display("FAIL basic_hold_after: got %0d expected 98", out_sum);
        end
    endtask

    task automatic test_overflow;
        logic [15:0] s;
        logic [7:0]  c;
        logic        o;
        beat(16'd65025, 1'b0);
        beat(16'd65025, 1'b1);
        get_result(1'b0, s, c, o);
        checks++;
        if (s !== 16'd64514 || c !== 8'd2 || o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_wrap: got %0d/%0d/%0b expected 64514/2/1", s, c, o);
        end
        beat(16'd3, 1'b1);
        get_result(1'b0, s, c, o);
        checks++;
        if (s !== 16'd3 || c !== 8'd1 || o !== 1'b0) begin
            errors++;
            $display("FAIL overflow_cleared: got %0d/%0d/%0b expected 3/1/0", s, c, o);
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] s;
        logic [7:0]  c;
        logic        o;
        out_ready = 1'b0;
        beat(16'd100, 1'b0);
        beat(16'd200, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_product = 16'd999;
            in_last    = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 16'd300
                || out_count !== 8'd2) begin
                errors++;
                $display("FAIL bp_hold[%0d]: rdy %0b vld %0b sum %0d cnt %0d expected 0 1 300 2",
                         i, in_ready, out_valid, out_sum, out_count);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got %0b expected 0", out_valid);
        end
        beat(16'd11, 1'b0);
        beat(16'd22, 1'b1);
        get_result(1'b0, s, c, o);
        checks++;
        if (s !== 16'd33 || c !== 8'd2 || o !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_group: got %0d/%0d/%0b expected 33/2/0", s, c, o);
        end
    endtask

    task automatic test_clear;
        logic [15:0] s;
        logic [7:0]  c;
        logic        o;
        beat(16'd50, 1'b0);
        beat(16'd60, 1'b0);
        @(negedge clk);
        clear      = 1'b1;
        in_valid   = 1'b1;
        in_product = 16'd70;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: got %0b expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        beat(16'd5, 1'b1);
        get_result(1'b0, s, c, o);
        checks++;
        if (s !== 16'd5 || c !== 8'd1 || o !== 1'b0) begin
            errors++;
            $display("FAIL clear_result: got %0d/%0d/%0b expected 5/1/0", s, c, o);
        end
    endtask

    task automatic test_clear_in_done;
        logic [15:0] s;
        logic [7:0]  c;
        logic        o;
        out_ready = 1'b0;
        beat(16'd40, 1'b1);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        get_result(1'b0, s, c, o);
        checks++;
        if (s !== 16'd40 || c !== 8'd1) begin
            errors++;
            $display("FAIL clear_in_done: got %0d/%0d expected 40/1", s, c);
        end
    endtask

    task automatic test_saturate;
        logic [15:0] s;
        logic [7:0]  c;
        logic        o;
        for (int i = 0; i < 260; i++) begin
            beat(16'd1, (i == 259) ? 1'b1 : 1'b0);
        end
        get_result(1'b0, s, c, o);
        checks++;
        if (s !== 16'd260 || c !== 8'd255 || o !== 1'b0) begin
            errors++;
            $display("FAIL count_saturate: got %0d/%0d/%0b expected 260/255/0", s, c, o);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] s;
        logic [7:0]  c;
        logic        o;
        beat(16'd1000, 1'b0);
        beat(16'd2000, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 16'd0 || out_count !== 8'd0
            || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outs: got %0b/%0d/%0d/%0b expected 0/0/0/0",
                     out_valid, out_sum, out_count, out_overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        beat(16'd7, 1'b1);
        get_result(1'b0, s, c, o);
        checks++;
        if (s !== 16'd7 || c !== 8'd1 || o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_next: got %0d/%0d/%0b expected 7/1/0", s, c, o);
        end
    endtask

    task automatic test_random;
        logic [15:0] s;
        logic [7:0]  c;
        logic        o;
        logic [16:0] t;
        logic [15:0] ms;
        logic [7:0]  mc;
        logic        mo;
        logic [15:0] p;
        int          len;
        for (int g = 0; g < 1000; g++) begin
            len = $urandom_range(1, 20);
            ms  = '0;
            mc  = '0;
            mo  = 1'b0;
            for (int b = 0; b < len; b++) begin
                p  = 16'($urandom_range(0, 255)) * 16'($urandom_range(0, 255));
                t  = {1'b0, ms} + {1'b0, p};
                ms = t[15:0];
                mo = mo | t[16];
                mc = (mc == 8'd255) ? mc : mc + 8'd1;
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                beat(p, (b == len - 1) ? 1'b1 : 1'b0);
            end
            get_result(1'b1, s, c, o);
            checks++;
            if (s !== ms || c !== mc || o !== mo) begin
                errors++;
                $display("FAIL random_group[%0d]: got %0d/%0d/%0b expected %0d/%0d/%0b",
                         g, s, c, o, ms, mc, mo);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overflow;
        test_backpressure;
        test_clear;
        test_clear_in_done;
        test_saturate;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulation stage that sits directly downstream of `digital_multiplier`. It consumes the 2N-bit unsigned products over a valid/ready stream and sums each group of products delimited by `in_last`. It presents the group sum, a beat count and a sticky overflow flag on a valid/ready output. Together with the multiplier it forms the datapath of a dot-product / MAC unit.

## Interface
- `N`, 8: operand width of the upstream multiplier; the product width is 2*N.
- `ACC_W`, 2*N+8: accumulator and output sum width; must be ≥ 2*N.
- `CNT_W`, 8: width of the beat counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `clear`  in  1  synchronous abort of the current group; discards the partial sum.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_product`  in  2*N  unsigned product from the multiplier.
- `in_last`  in  1  beat is the final term of the group.
- `out_valid`  out  1  group result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  ACC_W  group sum modulo 2^ACC_W.
- `out_count`  out  CNT_W  number of beats in the group; saturates at 2^CNT_W−1.
- `out_overflow`  out  1  a carry out of ACC_W occurred at some point in the group.

## Operation
- Two-state FSM: ACC (collecting beats) and DONE (holding the result).
- Reset state is ACC. In reset: `acc`=0, `cnt`=0, `ovf`=0, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_overflow`=0.
- `in_ready` = (state==ACC) && !`clear`. This is combinational and never depends on `in_valid`.
- A beat is accepted when `in_valid && in_ready`. On acceptance:
  - `acc` ← `acc` + zero-extended `in_product` (ACC_W+1-bit add; the sum is the low ACC_W bits).
  - `ovf` ← `ovf` | carry.
  - `cnt` ← min(`cnt`+1, 2^CNT_W−1).
- Accepted beat with `in_last`=1:
  - The final sum, count and overflow (including this beat) are registered onto `out_sum`, `out_count` and `out_overflow`.
  - `out_valid` ← 1, state → DONE.
  - `acc`, `cnt` and `ovf` are cleared in the same edge.
- DONE: `in_ready`=0. `out_*` are held stable while `out_valid`=1 and `out_ready`=0.
- DONE with `out_ready`=1: `out_valid` ← 0, state → ACC. The `out_sum`, `out_count` and `out_overflow` values remain until they are overwritten.
- `clear`=1 in ACC: `acc`, `cnt` and `ovf` ← 0, and no beat is accepted that cycle because `in_ready` is 0.
- `clear` in DONE has no effect; the pending result is never discarded.
- `in_last` on a beat that is not accepted is ignored.
- Zero-length groups do not exist; a group always contains at least one beat.
- `rst_n` low at any time, including mid-group or in DONE, immediately forces all reset values. The partial sum and any pending result are lost.

## Timing
- Latency: `out_valid` rises on the edge that accepts the `in_last` beat, i.e. it is visible in the next cycle.
- Throughput: one beat per cycle while in ACC.
  - Each group costs at least one extra cycle in DONE, because `in_ready`=0 in DONE.
  - A new group's first beat can be accepted in the cycle after the `out_valid`&&`out_ready` handshake.
- Beats with `in_valid`=1 and `in_ready`=0 must be held by upstream, under standard valid/ready semantics.
- No combinational path exists from `in_valid` or `in_product` to any output. The only combinational path is `clear` → `in_ready`.

## Test plan
- Basic group (N=8):
  - Stimulus: products 6, 20, 72 (from a·b = 2·3, 4·5, 8·9), `in_last` on the third, `out_ready`=1.
  - Required: `out_sum`=98, `out_count`=3, `out_overflow`=0, `out_valid` high for exactly 1 cycle.
- Overflow wrap (ACC_W=16, N=8):
  - Stimulus: 65025, 65025 (255·255 twice) with `in_last` on the second.
  - Required: `out_sum`=64514, `out_count`=2, `out_overflow`=1.
- Backpressure:
  - Stimulus: group 100, 200 (last), `out_ready`=0 for 5 cycles; a new `in_valid` is offered during DONE.
  - Required: `in_ready`=0 throughout; `out_sum`=300 stays stable; the next group starts correctly after `out_ready` is asserted.
- Clear:
  - Stimulus: 50, 60, then `clear` together with `in_valid` (70), then 5 (last).
  - Required: the 70 beat is not accepted; the group result is `out_sum`=5, `out_count`=1.
- Reset mid-group:
  - Stimulus: 1000, 2000 accepted, then `rst_n`=0 asynchronously between edges.
  - Required: all outputs are 0 immediately. The next group 7 (last) yields `out_sum`=7, `out_count`=1.
- Random:
  - Stimulus: 1000 groups of 1–20 beats, with products formed as `$urandom` a·b and random `out_ready`.
  - Required: every result matches a reference model of the modulo sum, saturated count and carry flag.
